// File: rtl/cut_bist_ctrl.sv
// cut_bist_ctrl
// Built-in self-test controller for the 4-input benchmark circuit
//   l = ((a & b) | ~(b & c)) & e
// It walks vectors 0..NUM_VEC-1 onto {cut_a,cut_b,cut_c,cut_e}. For each
// vector it waits SETTLE cycles and then samples cut_l against a golden model.
// It reports a saturating mismatch count, the first failing vector and an
// overall pass flag.
//
// Optional feature, controlled by the macro CUT_BIST_MISR_EN:
//   defined   - an 8-bit MISR (x^8+x^4+x^3+x^2+1, seed 0) compacts cut_l into
//               the signature output.
//   undefined - no MISR is built and signature is tied to 8'h00.

module cut_bist_ctrl #(
  parameter int NUM_VEC = 16,  // vectors applied, 1..16
  parameter int SETTLE  = 1,   // settle cycles per vector, >= 1
  parameter int CNT_W   = 5    // width of fail_cnt
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             cut_a,
  output logic             cut_b,
  output logic             cut_c,
  output logic             cut_e,
  input  logic             cut_l,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_valid,
  output logic [7:0]       signature
);

  // Settle counter counts 0..SETTLE-1; keep it at least one bit wide.
  localparam int               SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [3:0]       LAST_IDX    = 4'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [3:0]       idx_q;        // index of the vector under test
  logic [3:0]       vec_q;        // registered {a,b,c,e} driven to the CUT
  logic [SW-1:0]    settle_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [3:0]       ff_vec_q;
  logic             ff_valid_q;

  logic             exp_l;
  logic             mismatch;
  logic [CNT_W-1:0] fail_cnt_d;
  logic             start_run;
  logic             abort_run;

  // Golden response, mismatch detection and saturating count increment.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here
    // unconditionally) so that no latch is inferred.
    exp_l      = ((vec_q[3] & vec_q[2]) | ~(vec_q[2] & vec_q[1])) & vec_q[0];
    mismatch   = (cut_l != exp_l);
    fail_cnt_d = (fail_cnt_q == CNT_MAX) ? fail_cnt_q : fail_cnt_q + CNT_W'(1);
    // abort beats start in IDLE and stops a run in every other state.
    start_run  = (state_q == ST_IDLE) && start && !abort;
    abort_run  = (state_q != ST_IDLE) && abort;
  end

  // Sequencer FSM with all status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is a plain flop with a reset value; there is
    // no memory array, so nothing is left unreset.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      vec_q      <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // read in this block sees the value from before the clock edge.
      done_q <= 1'b0;
      if (abort_run) begin
        // Partial results (fail_cnt, first_fail_*) are kept on purpose.
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        vec_q   <= '0;
        pass_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start_run) begin
              state_q    <= ST_APPLY;
              busy_q     <= 1'b1;
              idx_q      <= '0;
              vec_q      <= '0;
              fail_cnt_q <= '0;
              ff_valid_q <= 1'b0;
              pass_q     <= 1'b0;
            end
          end
          ST_APPLY: begin
            state_q  <= ST_WAIT;
            settle_q <= '0;
          end
          ST_WAIT: begin
            if (settle_q == SETTLE_LAST) begin
              state_q <= ST_CHECK;
            end else begin
              settle_q <= settle_q + SW'(1);
            end
          end
          ST_CHECK: begin
            if (mismatch) begin
              fail_cnt_q <= fail_cnt_d;
              if (!ff_valid_q) begin
                ff_valid_q <= 1'b1;
                ff_vec_q   <= idx_q;
              end
            end
            if (idx_q == LAST_IDX) begin
              // pass is set together with done from the final count.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              vec_q   <= '0;
              pass_q  <= !mismatch && (fail_cnt_q == '0);
            end else begin
              state_q <= ST_APPLY;
              idx_q   <= idx_q + 4'd1;
              vec_q   <= idx_q + 4'd1;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
          end
        endcase
      end
    end
  end

`ifdef CUT_BIST_MISR_EN
  localparam logic [7:0] MISR_POLY = 8'h1D;  // x^4+x^3+x^2+1 taps

  logic [7:0] sig_q;
  logic [7:0] sig_d;
  logic       sig_fb;

  // Next MISR value: shift left, fold in cut_l through the top bit.
  always_comb begin
    sig_fb = sig_q[7] ^ cut_l;
    sig_d  = {sig_q[6:0], 1'b0} ^ ({8{sig_fb}} & MISR_POLY);
  end

  // Signature register: cleared at run start, advanced once per CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (start_run) begin
      sig_q <= '0;
    end else if ((state_q == ST_CHECK) && !abort) begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`else
  assign signature = 8'h00;
`endif

  assign cut_a            = vec_q[3];
  assign cut_b            = vec_q[2];
  assign cut_c            = vec_q[1];
  assign cut_e            = vec_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_cnt         = fail_cnt_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_cut_bist_ctrl.sv
// Testbench for cut_bist_ctrl: a behavioural CUT with selectable faults,
// an expected-result queue filled at each run start, and a done-driven
// monitor that pops and compares.
`timescale 1ns/1ps

module tb_cut_bist_ctrl;

  localparam int CNT_W = 5;
  localparam int RUN_LAT = 48;  // cycles from first APPLY to done

  // Fault modes of the behavioural CUT.
  localparam int F_NONE = 0;
  localparam int F_SA0  = 1;  // output stuck-at-0
  localparam int F_SA1  = 2;  // output stuck-at-1
  localparam int F_AND0 = 3;  // (a&b) stuck-at-0

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             cut_a, cut_b, cut_c, cut_e, cut_l;
  logic             busy, done, pass;
  logic [CNT_W-1:0] fail_cnt;
  logic [3:0]       first_fail_vec;
  logic             first_fail_valid;
  logic [7:0]       signature;
  int               fault_mode = F_NONE;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             ffv;
    logic [3:0]       ffvec;
    logic             pass;
    logic [7:0]       sig;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   apply_cyc = 0;
  logic busy_prev = 1'b0;

  always #5 clk = ~clk;

  cut_bist_ctrl #(.NUM_VEC(16), .SETTLE(1), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .cut_a            (cut_a),
    .cut_b            (cut_b),
    .cut_c            (cut_c),
    .cut_e            (cut_e),
    .cut_l            (cut_l),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .fail_cnt         (fail_cnt),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid),
    .signature        (signature)
  );

  function automatic logic cut_resp(input logic [3:0] v, input int mode);
    logic a, b, c, e;
    {a, b, c, e} = v;
    case (mode)
      F_SA0:   return 1'b0;
      F_SA1:   return 1'b1;
      F_AND0:  return (1'b0 | ~(b & c)) & e;
      default: return ((a & b) | ~(b & c)) & e;
    endcase
  endfunction

  always_comb cut_l = cut_resp({cut_a, cut_b, cut_c, cut_e}, fault_mode);

  // Reference MISR over a full fault-mode run.
  function automatic logic [7:0] ref_sig(input int mode);
    logic [7:0] s;
    logic       fb;
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      fb = s[7] ^ cut_resp(4'(i), mode);
      s  = {s[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
    end
`ifdef CUT_BIST_MISR_EN
    return s;
`else
    return (s == s) ? 8'h00 : 8'hFF;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: on each done pulse pop the expected result and compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) apply_cyc = cyc;
      busy_prev = busy;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("latency", 32'(cyc - apply_cyc), 32'(RUN_LAT));
          check("fail_cnt", 32'(fail_cnt), 32'(mon_e.cnt));
          check("ff_valid", 32'(first_fail_valid), 32'(mon_e.ffv));
          if (mon_e.ffv) check("ff_vec", 32'(first_fail_vec), 32'(mon_e.ffvec));
          check("pass", 32'(pass), 32'(mon_e.pass));
          check("signature", 32'(signature), 32'(mon_e.sig));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int mode, input int cnt, input logic ffv,
                          input int ffvec, input logic p);
    exp_t e;
    e.cnt   = CNT_W'(cnt);
    e.ffv   = ffv;
    e.ffvec = 4'(ffvec);
    e.pass  = p;
    e.sig   = ref_sig(mode);
    exp_q.push_back(e);
  endtask

  // Start one run in the given fault mode with a one-cycle start pulse.
  task automatic pulse_start(input int mode);
    fault_mode = mode;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Wait (bounded) for a done pulse; returns at the DONE-cycle negedge.
  task automatic wait_done(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_fail_cnt"}, 32'(fail_cnt), 32'd0);
    check({tag, "_ff_valid"}, 32'(first_fail_valid), 32'd0);
    check({tag, "_ff_vec"}, 32'(first_fail_vec), 32'd0);
    check({tag, "_sig"}, 32'(signature), 32'd0);
    check({tag, "_vec"}, 32'({cut_a, cut_b, cut_c, cut_e}), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen5;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick(2);

    // Fault-free run.
    push_exp(F_NONE, 0, 1'b0, 0, 1'b1);
    pulse_start(F_NONE);
    wait_done("done_free");
    tick(3);
    check("free_pass_hold", 32'(pass), 32'd1);
    check("free_busy_after", 32'(busy), 32'd0);
    check("free_vec_idle", 32'({cut_a, cut_b, cut_c, cut_e}), 32'd0);

    // Output stuck-at-0: seven vectors expect 1, first is vector 1.
    push_exp(F_SA0, 7, 1'b1, 1, 1'b0);
    pulse_start(F_SA0);
    wait_done("done_sa0");
    tick(5);
    check("sa0_cnt_hold", 32'(fail_cnt), 32'd7);
    check("sa0_pass_hold", 32'(pass), 32'd0);

    // Output stuck-at-1: nine vectors expect 0, first is vector 0.
    push_exp(F_SA1, 9, 1'b1, 0, 1'b0);
    pulse_start(F_SA1);
    wait_done("done_sa1");
    tick(2);

    // AND gate stuck-at-0: only a=b=c=e=1 exposes it.
    push_exp(F_AND0, 1, 1'b1, 15, 1'b0);
    pulse_start(F_AND0);
    wait_done("done_and0");
    tick(2);

    // Abort during vector 5's WAIT (stuck-at-1, so vectors 0,2,4 failed).
    pulse_start(F_SA1);
    seen5 = 1'b0;
    for (int i = 0; i < 100 && !seen5; i++) begin
      if ({cut_a, cut_b, cut_c, cut_e} == 4'd5) seen5 = 1'b1;
      else @(negedge clk);
    end
    check("abort_reach_v5", 32'(seen5), 32'd1);
    tick(1);            // now in WAIT for vector 5
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_vec", 32'({cut_a, cut_b, cut_c, cut_e}), 32'd0);
    check("abort_cnt", 32'(fail_cnt), 32'd3);
    check("abort_ffv", 32'(first_fail_valid), 32'd1);
    check("abort_ffvec", 32'(first_fail_vec), 32'd0);
    tick(60);
    check("abort_still_idle", 32'(busy), 32'd0);

    // abort and start together in IDLE: no run.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    tick(1);
    check("abort_wins_busy", 32'(busy), 32'd0);
    check("abort_wins_cnt", 32'(fail_cnt), 32'd3);

    // Clean run after abort; a second start while busy is ignored.
    push_exp(F_NONE, 0, 1'b0, 0, 1'b1);
    pulse_start(F_NONE);
    tick(10);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("done_after_abort");
    tick(2);

    // start held high: a new run follows DONE via one IDLE cycle.
    push_exp(F_AND0, 1, 1'b1, 15, 1'b0);
    push_exp(F_AND0, 1, 1'b1, 15, 1'b0);
    fault_mode = F_AND0;
    start = 1'b1;
    wait_done("done_held_1");
    tick(1);
    check("held_idle_gap", 32'(busy), 32'd0);
    tick(1);
    check("held_restart", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("done_held_2");
    tick(2);

    // Reset mid-run: immediate reset values, no done afterwards.
    pulse_start(F_SA0);
    tick(20);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    start = 1'b1;
    tick(2);
    check("midrst_start_ignored", 32'(busy), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    tick(60);
    check("midrst_idle", 32'(busy), 32'd0);

    // Recovery run.
    push_exp(F_NONE, 0, 1'b0, 0, 1'b1);
    pulse_start(F_NONE);
    wait_done("done_recover");
    tick(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cut_bist_ctrl.md
Name: cut_bist_ctrl

Overview:
- Built-in self-test controller for the 4-input fault-detection benchmark circuit l = ((a&b) | ~(b&c)) & e, the circuit-under-test (CUT).
- On start, applies every input vector to the CUT in sequence and waits a programmable settle time.
- Samples the CUT output and compares it against an internal golden model.
- Reports a mismatch count, the first failing vector and an overall pass flag, so the bench or a higher-level test manager can detect injected faults.

Parameters:
NUM_VEC, 16, number of vectors applied; vector index runs 0..NUM_VEC-1 (max 16)
SETTLE, 1, wait cycles between driving a vector and sampling cut_l (min 1)
CNT_W, 5, width of fail_cnt

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; a run begins when start=1 in IDLE
abort  input  1  stops a run in progress
cut_a  output  1  CUT input a
cut_b  output  1  CUT input b
cut_c  output  1  CUT input c
cut_e  output  1  CUT input e
cut_l  input  1  CUT response
busy  output  1  high from the first APPLY until the return to IDLE
done  output  1  one-cycle pulse at normal completion
pass  output  1  high when the last completed run had fail_cnt==0
fail_cnt  output  CNT_W  number of mismatching vectors, saturating
first_fail_vec  output  4  index of the first mismatching vector
first_fail_valid  output  1  first_fail_vec holds a valid index
signature  output  8  MISR signature (optional feature; 0 when the feature is disabled)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cut_* = 0; busy, done, pass, first_fail_valid = 0; fail_cnt = 0; first_fail_vec = 0; signature = 0; internal vector index = 0.
- The clock and reset ports are named clk and rst_n; there is one clock, and reset is asynchronous and active-low.
- Vector mapping: {cut_a,cut_b,cut_c,cut_e} = idx[3:0], registered outputs.
- Golden model: exp = ((a&b) | ~(b&c)) & e, computed from the registered vector.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
  - IDLE: when start=1, clear fail_cnt, first_fail_valid, pass and signature, set idx=0, go to APPLY.
  - APPLY (1 cycle): drive vector idx on cut_*, busy=1, go to WAIT.
  - WAIT: hold the vector for SETTLE cycles using an internal counter, then go to CHECK.
  - CHECK (1 cycle): sample cut_l and compare with exp.
    - On mismatch, fail_cnt increments, saturating at 2^CNT_W-1.
    - On the first mismatch of the run, first_fail_vec=idx and first_fail_valid=1.
    - If idx==NUM_VEC-1 go to DONE; otherwise idx+1 and go to APPLY.
  - DONE (1 cycle): done=1, pass=(fail_cnt==0), busy=0 next cycle, go to IDLE. Outputs cut_* return to 0.
- Timing: each vector takes SETTLE+2 cycles. A run takes NUM_VEC*(SETTLE+2) cycles from APPLY entry to DONE; with the defaults, done is asserted 48 cycles after the first APPLY.
- start is ignored outside IDLE. If start is held high continuously, a new run begins on the cycle after DONE.
- abort=1 in any non-IDLE state: go to IDLE next cycle with busy=0 and cut_*=0. done is not pulsed, pass is forced to 0, and fail_cnt and first_fail_* keep their partial values. abort in IDLE has no effect.
- abort and start high together in IDLE: abort wins, no run starts.
- Reset asserted mid-run: immediate return to the reset values listed above, with no done pulse.
- Results (pass, fail_cnt, first_fail_*, signature) hold until the next run starts.

Optional Feature:
- Macro: CUT_BIST_MISR_EN.
- Defined: an 8-bit MISR with polynomial x^8+x^4+x^3+x^2+1 and seed 8'h00, cleared at run start.
  - In each CHECK cycle it shifts left; the feedback bit is sig[7] XOR cut_l.
  - signature holds the final value after DONE, and the value reached so far after an abort.
- Undefined: no MISR logic is built and signature is tied to 8'h00.

Test Plan:
- Fault-free CUT model, defaults, start pulse -> done 48 cycles after the first APPLY; pass=1, fail_cnt=0, first_fail_valid=0.
- cut_l stuck-at-0 -> fail_cnt=7, first_fail_vec=1, pass=0.
- cut_l stuck-at-1 -> fail_cnt=9, first_fail_vec=0, pass=0.
- AND gate output (a&b) stuck-at-0 in the CUT -> fail_cnt=1, first_fail_vec=15.
- abort asserted during vector 5's WAIT -> busy=0 next cycle, no done pulse, pass=0; a following start gives a clean fault-free result.
- rst_n low mid-run, then start ignored while busy -> all outputs at reset values. With CUT_BIST_MISR_EN defined, the fault-free signature matches the bench's reference MISR model.
